// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding, default
// operand width and the full-adder carry function.
package serial_adder_pkg;

    localparam int unsigned DefaultWidth = 8;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

    // Carry out of a full adder is the majority of its three inputs.
    function automatic logic majority(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/fa_bit.sv
// Combinational 1-bit full adder: the single arithmetic cell of the serial
// datapath.
module fa_bit
    import serial_adder_pkg::*;
(
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);

    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = majority(a_i, b_i, ci_i);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple adder. Captures two WIDTH-bit operands on an accepted
// start, then adds one bit per clock (LSB first) through a single fa_bit and
// a registered carry. The result appears with a one-cycle done pulse and is
// held until the next completion.
//
// Build option: define SERIAL_ADDER_SUB_EN to add the sub_i port; an accepted
// start with sub_i=1 computes a-b (B loaded inverted, carry forced to 1).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub_i,
`endif
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    state_e            state_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    // Upper WIDTH-1 result bits collected so far; the current bit completes it.
    logic [WIDTH-2:0]  work_q;
    logic              carry_q;
    logic [CntW-1:0]   cnt_q;
    logic [WIDTH-1:0]  sum_q;
    logic              cout_q;

    logic              fa_s;
    logic              fa_co;
    logic [WIDTH-1:0]  work_ext;
    logic [WIDTH-1:0]  b_load;
    logic              carry_load;

    fa_bit u_fa_bit (
        .a_i  (a_q[0]),
        .b_i  (b_q[0]),
        .ci_i (carry_q),
        .s_o  (fa_s),
        .co_o (fa_co)
    );

    // Operand conditioning applied at the accept edge.
`ifdef SERIAL_ADDER_SUB_EN
    assign b_load     = sub_i ? ~b_i : b_i;
    assign carry_load = sub_i ? 1'b1 : cin_i;
`else
    assign b_load     = b_i;
    assign carry_load = cin_i;
`endif

    // New sum bit enters at the MSB; after WIDTH shifts this is the full result.
    assign work_ext = {fa_s, work_q};

    // Control FSM plus serial datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start_i) begin
                        a_q     <= a_i;
                        b_q     <= b_load;
                        work_q  <= '0;
                        carry_q <= carry_load;
                        cnt_q   <= '0;
                        state_q <= StRun;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    carry_q <= fa_co;
                    work_q  <= work_ext[WIDTH-1:1];
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    if (cnt_q == LastBit) begin
                        // Outputs only update here, so partial sums stay hidden.
                        sum_q   <= work_ext;
                        cout_q  <= fa_co;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o = (state_q == StRun);
    assign done_o = (state_q == StDone);
    assign sum_o  = sum_q;
    assign cout_o = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8). A scoreboard queue holds the
// expected result of each accepted operation; a monitor pops and compares on
// every done pulse. Subtract cases run only when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk     = 1'b0;
    logic         rst_n   = 1'b0;
    logic         start_i = 1'b0;
    logic [W-1:0] a_i     = '0;
    logic [W-1:0] b_i     = '0;
    logic         cin_i   = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub_i   = 1'b0;
`endif
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] sum_o;
    logic         cout_o;

    always #5 clk = ~clk;

    serial_adder #(
        .WIDTH (W)
    ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .cin_i   (cin_i),
`ifdef SERIAL_ADDER_SUB_EN
        .sub_i   (sub_i),
`endif
        .busy_o  (busy_o),
        .done_o  (done_o),
        .sum_o   (sum_o),
        .cout_o  (cout_o)
    );

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
    } res_t;

    int           n_total = 0;
    int           n_bad   = 0;
    res_t         exp_q[$];
    res_t         mon_e;
    logic [W-1:0] prev_sum  = '0;
    logic         prev_cout = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference arithmetic: full (W+1)-bit sum, subtract as a + ~b + 1.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c, input logic s);
        logic [W:0] t;
        res_t       r;
        t = {1'b0, a} + {1'b0, (s ? ~b : b)} + {{W{1'b0}}, (s ? 1'b1 : c)};
        r.sum  = t[W-1:0];
        r.cout = t[W];
        return r;
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest pending result.
    always @(negedge clk) begin
        if (done_o) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", 32'(done_o), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_sum", 32'(sum_o), 32'(mon_e.sum));
                check("sb_cout", 32'(cout_o), 32'(mon_e.cout));
                prev_sum  = mon_e.sum;
                prev_cout = mon_e.cout;
            end
        end
    end

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic s);
        a_i   = a;
        b_i   = b;
        cin_i = c;
`ifdef SERIAL_ADDER_SUB_EN
        sub_i = s;
`endif
        exp_q.push_back(model(a, b, c, s));
    endtask

    // One isolated operation with cycle-exact busy/done and output-hold checks.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic s);
        @(negedge clk);
        start_i = 1'b1;
        drive(a, b, c, s);
        @(negedge clk);
        start_i = 1'b0;
        a_i     = W'($urandom);
        b_i     = W'($urandom);
        cin_i   = 1'($urandom);
        for (int i = 1; i <= W; i++) begin
            if (i > 1) @(negedge clk);
            check("busy_run", 32'(busy_o), 32'd1);
            check("done_early", 32'(done_o), 32'd0);
            check("sum_hold", 32'(sum_o), 32'(prev_sum));
        end
        @(negedge clk);
        check("done_pulse", 32'(done_o), 32'd1);
        check("busy_in_done", 32'(busy_o), 32'd0);
        @(negedge clk);
        check("done_one_cycle", 32'(done_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_sum", 32'(sum_o), 32'd0);
        check("rst_cout", 32'(cout_o), 32'd0);
        rst_n = 1'b1;

        // Test-plan cases with literal expectations.
        run_op(8'h5A, 8'h3C, 1'b0, 1'b0);
        check("tp_5a_3c_sum", 32'(sum_o), 32'h96);
        check("tp_5a_3c_cout", 32'(cout_o), 32'd0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0);
        check("tp_ff_01_sum", 32'(sum_o), 32'h00);
        check("tp_ff_01_cout", 32'(cout_o), 32'd1);
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0);
        check("tp_ff_ff_sum", 32'(sum_o), 32'hFF);
        check("tp_ff_ff_cout", 32'(cout_o), 32'd1);

        // Random additions.
        for (int k = 0; k < 6; k++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
        end

        // Start held high: operands wiggle during RUN, second op taken in DONE.
        @(negedge clk);
        start_i = 1'b1;
        drive(8'hC3, 8'h7E, 1'b1, 1'b0);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (!done_o) begin
                a_i   = W'($urandom);
                b_i   = W'($urandom);
                cin_i = 1'($urandom);
            end
        end while (!done_o && cnt < 40);
        check("b2b_first_latency", 32'(cnt), 32'(W + 1));
        drive(8'h12, 8'h34, 1'b0, 1'b0);
        @(negedge clk);
        start_i = 1'b0;
        cnt = 1;
        while (!done_o && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check("b2b_no_gap", 32'(cnt), 32'(W + 1));
        @(negedge clk);
        check("b2b_sum_held", 32'(sum_o), 32'h46);

        // Abort mid-run with asynchronous reset; aborted op is not scoreboarded.
        start_i = 1'b1;
        a_i     = 8'hAA;
        b_i     = 8'h55;
        cin_i   = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_done", 32'(done_o), 32'd0);
        check("abort_sum", 32'(sum_o), 32'd0);
        check("abort_cout", 32'(cout_o), 32'd0);
        prev_sum  = '0;
        prev_cout = 1'b0;
        @(negedge clk);
        check("abort_no_done", 32'(done_o), 32'd0);
        rst_n = 1'b1;
        run_op(8'h01, 8'h02, 1'b0, 1'b0);
        check("post_rst_sum", 32'(sum_o), 32'h03);
        check("post_rst_cout", 32'(cout_o), 32'd0);

`ifdef SERIAL_ADDER_SUB_EN
        run_op(8'h10, 8'h20, 1'b0, 1'b1);
        check("sub_10_20_sum", 32'(sum_o), 32'hF0);
        check("sub_10_20_cout", 32'(cout_o), 32'd0);
        run_op(8'h20, 8'h10, 1'b1, 1'b1);
        check("sub_20_10_sum", 32'(sum_o), 32'h10);
        check("sub_20_10_cout", 32'(cout_o), 32'd1);
        run_op(8'h20, 8'h10, 1'b1, 1'b0);
        check("sub_off_sum", 32'(sum_o), 32'h31);
`endif

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
